// File: rtl/frog_collision_ctrl.sv
// frog_collision_ctrl
//
// Purpose:
//   This block sits on the consumer side of the car position interface.
//   It compares the frog grid position against every lane's car and raises
//   a hit when they overlap. It also detects when the frog reaches the goal
//   row. Finally, it runs the life / level / respawn state machine that
//   freezes the frog, brings it back to its start cell, and ends the game.
//
// Ports:
//   i_Clk        system clock
//   i_Rst_n      asynchronous active-low reset
//   i_tick       frame-rate enable pulse, one i_Clk cycle wide
//   i_start      restart request, honoured only while the game is over
//   i_car_x      packed car X positions, lane k in bits [5k+4:5k]
//   i_frog_x     frog column
//   i_frog_y     frog row
//   o_hit        one-cycle pulse on collision
//   o_level_up   one-cycle pulse when the goal row is reached
//   o_respawn    one-cycle pulse telling the frog mover to reset the frog
//   o_freeze     high while frog input must be ignored
//   o_lives      remaining lives
//   o_level      current level (1..MAX_LEVEL), fed back to the car movers
//   o_game_over  high while the game is over

module frog_collision_ctrl #(
    parameter int NUM_LANES     = 4,
    parameter int GRID_W        = 20,
    parameter int LANE_ROW_BASE = 2,
    parameter int GOAL_ROW      = 0,
    parameter int CAR_LEN       = 2,
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 60,
    parameter int MAX_LEVEL     = 40
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_tick,
    input  logic                   i_start,
    input  logic [5*NUM_LANES-1:0] i_car_x,
    input  logic [4:0]             i_frog_x,
    input  logic [3:0]             i_frog_y,
    output logic                   o_hit,
    output logic                   o_level_up,
    output logic                   o_respawn,
    output logic                   o_freeze,
    output logic [2:0]             o_lives,
    output logic [5:0]             o_level,
    output logic                   o_game_over
);

    localparam int TIMER_W = (RESPAWN_TICKS < 2) ? 1 : $clog2(RESPAWN_TICKS + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESPAWN_TICKS);

    typedef enum logic [1:0] {
        PLAY,
        HIT,
        RESPAWN,
        OVER
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               overlap;
    logic               goal;
    int                 car_val;
    int                 cell_val;

    // A car covers CAR_LEN cells starting at its X position. The covered
    // cells wrap around the right edge of the grid. A car value outside the
    // grid means that lane is empty, so it can never collide.
    always_comb begin
        overlap  = 1'b0;
        car_val  = 0;
        cell_val = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            car_val = int'(i_car_x[5*k +: 5]);
            if (car_val < GRID_W && int'(i_frog_y) == LANE_ROW_BASE + k) begin
                for (int j = 0; j < CAR_LEN; j++) begin
                    cell_val = (car_val + j) % GRID_W;
                    if (int'(i_frog_x) == cell_val) begin
                        overlap = 1'b1;
                    end
                end
            end
        end
    end

    assign goal = (int'(i_frog_y) == GOAL_ROW);

    // Game state machine. Every output is registered. The pulse outputs
    // default low each cycle, so each one lasts exactly one cycle. Only one
    // transition can happen per edge, so two pulses never overlap.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= PLAY;
            timer       <= '0;
            o_lives     <= 3'(LIVES);
            o_level     <= 6'd1;
            o_hit       <= 1'b0;
            o_level_up  <= 1'b0;
            o_respawn   <= 1'b0;
            o_freeze    <= 1'b0;
            o_game_over <= 1'b0;
        end else begin
            o_hit      <= 1'b0;
            o_level_up <= 1'b0;
            o_respawn  <= 1'b0;
            case (state)
                PLAY: begin
                    if (overlap) begin
                        state    <= HIT;
                        o_hit    <= 1'b1;
                        o_freeze <= 1'b1;
                        if (o_lives != 3'd0) begin
                            o_lives <= o_lives - 3'd1;
                        end
                    end else if (goal) begin
                        state      <= RESPAWN;
                        o_level_up <= 1'b1;
                        o_freeze   <= 1'b1;
                        timer      <= TIMER_LOAD;
                        if (o_level < 6'(MAX_LEVEL)) begin
                            o_level <= o_level + 6'd1;
                        end
                    end
                end
                HIT: begin
                    if (o_lives == 3'd0) begin
                        state       <= OVER;
                        o_game_over <= 1'b1;
                    end else begin
                        state <= RESPAWN;
                        timer <= TIMER_LOAD;
                    end
                end
                RESPAWN: begin
                    // The exit check comes before the tick. This means a
                    // tick that arrives while the timer is already zero
                    // has no effect.
                    if (timer == '0) begin
                        state     <= PLAY;
                        o_freeze  <= 1'b0;
                        o_respawn <= 1'b1;
                    end else if (i_tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                OVER: begin
                    if (i_start) begin
                        state       <= PLAY;
                        o_freeze    <= 1'b0;
                        o_game_over <= 1'b0;
                        o_lives     <= 3'(LIVES);
                        o_level     <= 6'd1;
                        o_respawn   <= 1'b1;
                    end
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule
